// File: rtl/axis_signalled_fifo.sv
// AXI-Stream FWFT FIFO with fill-level flags, synchronous flush and optional
// store-and-forward packet mode (release only whole TLAST-terminated packets).
module axis_signalled_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int USER_WIDTH  = 4,
  parameter int DEPTH       = 16,
  parameter int AF_THRESH   = DEPTH - 4,
  parameter int AE_THRESH   = 2,
  parameter int PACKET_MODE = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        clear_i,
  input  logic [DATA_WIDTH-1:0]       in_tdata_i,
  input  logic [DATA_WIDTH/8-1:0]     in_tkeep_i,
  input  logic                        in_tlast_i,
  input  logic [USER_WIDTH-1:0]       in_tuser_i,
  input  logic                        in_tvalid_i,
  output logic                        in_tready_o,
  output logic [DATA_WIDTH-1:0]       out_tdata_o,
  output logic [DATA_WIDTH/8-1:0]     out_tkeep_o,
  output logic                        out_tlast_o,
  output logic [USER_WIDTH-1:0]       out_tuser_o,
  output logic                        out_tvalid_o,
  input  logic                        out_tready_i,
  output logic [$clog2(DEPTH):0]      level_o,
  output logic                        empty_o,
  output logic                        full_o,
  output logic                        half_full_o,
  output logic                        almost_full_o,
  output logic                        almost_empty_o,
  output logic                        pkt_err_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int PW   = AW + 1;
  localparam int KW   = DATA_WIDTH / 8;
  localparam int PAYW = USER_WIDTH + 1 + KW + DATA_WIDTH;

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("axis_signalled_fifo: DEPTH must be a power of two >= 4");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("axis_signalled_fifo: AF_THRESH out of range 1..DEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
    $error("axis_signalled_fifo: AE_THRESH out of range 0..DEPTH-1");
  end

  logic [PAYW-1:0] mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   level_q, level_d;
  logic [PW-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic            drain_q, drain_d;
  logic            pkt_err_q, pkt_err_d;
  logic            ptr_full, ptr_empty;
  logic            push, pop, push_last, pop_last;
  logic [PAYW-1:0] rd_word;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign ptr_empty = (wr_ptr_q == rd_ptr_q);
  assign ptr_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign rd_word     = mem_q[rd_ptr_q[AW-1:0]];
  assign out_tdata_o = rd_word[DATA_WIDTH-1:0];
  assign out_tkeep_o = rd_word[DATA_WIDTH +: KW];
  assign out_tlast_o = rd_word[DATA_WIDTH + KW];
  assign out_tuser_o = rd_word[PAYW-1 -: USER_WIDTH];

  assign in_tready_o  = !ptr_full;
  assign out_tvalid_o = !ptr_empty &&
                        ((PACKET_MODE == 0) || (pkt_cnt_q != '0) || drain_q);

  assign push      = in_tvalid_i && in_tready_o;
  assign pop       = out_tvalid_o && out_tready_i;
  assign push_last = push && in_tlast_i;
  assign pop_last  = pop && out_tlast_o;

  assign level_o        = level_q;
  assign empty_o        = (level_q == '0);
  assign full_o         = (level_q == PW'(DEPTH));
  assign half_full_o    = (level_q > PW'(DEPTH / 2));
  assign almost_full_o  = (level_q >= PW'(AF_THRESH));
  assign almost_empty_o = (level_q <= PW'(AE_THRESH));
  assign pkt_err_o      = pkt_err_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    pkt_cnt_d = pkt_cnt_q;
    drain_d   = drain_q;
    pkt_err_d = pkt_err_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + PW'(1);
      2'b01:   level_d = level_q - PW'(1);
      default: level_d = level_q;
    endcase

    if (PACKET_MODE != 0) begin
      if (push_last && !pop_last)      pkt_cnt_d = pkt_cnt_q + PW'(1);
      else if (!pop_last && !push_last) pkt_cnt_d = pkt_cnt_q;
      else if (pop_last && !push_last) pkt_cnt_d = pkt_cnt_q - PW'(1);
      // A full FIFO holding no complete packet would deadlock; fall back to cut-through.
      if (ptr_full && (pkt_cnt_q == '0)) begin
        drain_d   = 1'b1;
        pkt_err_d = 1'b1;
      end
      if (pop_last) drain_d = 1'b0;
    end

    if (clear_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      pkt_cnt_d = '0;
      drain_d   = 1'b0;
      pkt_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      pkt_cnt_q <= '0;
      drain_q   <= 1'b0;
      pkt_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      pkt_cnt_q <= pkt_cnt_d;
      drain_q   <= drain_d;
      pkt_err_q <= pkt_err_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (push && !clear_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {in_tuser_i, in_tlast_i, in_tkeep_i, in_tdata_i};
    end
  end

endmodule

// File: tb/tb_axis_signalled_fifo.sv
// Scoreboard bench: one streaming-mode and one packet-mode FIFO instance,
// directed stimulus pushes expected beats, negedge monitors pop and compare.
module tb_axis_signalled_fifo;

  typedef logic [40:0] beat_t;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic rst_n_i;

  logic        a_clr, a_ilast, a_ivalid, a_iready, a_olast, a_ovalid, a_oready;
  logic [31:0] a_idata, a_odata;
  logic [3:0]  a_ikeep, a_okeep, a_iuser, a_ouser;
  logic [4:0]  a_level;
  logic        a_empty, a_full, a_hf, a_af, a_ae, a_perr;

  logic        b_clr, b_ilast, b_ivalid, b_iready, b_olast, b_ovalid, b_oready;
  logic [31:0] b_idata, b_odata;
  logic [3:0]  b_ikeep, b_okeep, b_iuser, b_ouser;
  logic [4:0]  b_level;
  logic        b_empty, b_full, b_hf, b_af, b_ae, b_perr;

  axis_signalled_fifo a_dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clear_i(a_clr),
    .in_tdata_i(a_idata), .in_tkeep_i(a_ikeep), .in_tlast_i(a_ilast),
    .in_tuser_i(a_iuser), .in_tvalid_i(a_ivalid), .in_tready_o(a_iready),
    .out_tdata_o(a_odata), .out_tkeep_o(a_okeep), .out_tlast_o(a_olast),
    .out_tuser_o(a_ouser), .out_tvalid_o(a_ovalid), .out_tready_i(a_oready),
    .level_o(a_level), .empty_o(a_empty), .full_o(a_full), .half_full_o(a_hf),
    .almost_full_o(a_af), .almost_empty_o(a_ae), .pkt_err_o(a_perr)
  );

  axis_signalled_fifo #(.PACKET_MODE(1)) b_dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clear_i(b_clr),
    .in_tdata_i(b_idata), .in_tkeep_i(b_ikeep), .in_tlast_i(b_ilast),
    .in_tuser_i(b_iuser), .in_tvalid_i(b_ivalid), .in_tready_o(b_iready),
    .out_tdata_o(b_odata), .out_tkeep_o(b_okeep), .out_tlast_o(b_olast),
    .out_tuser_o(b_ouser), .out_tvalid_o(b_ovalid), .out_tready_i(b_oready),
    .level_o(b_level), .empty_o(b_empty), .full_o(b_full), .half_full_o(b_hf),
    .almost_full_o(b_af), .almost_empty_o(b_ae), .pkt_err_o(b_perr)
  );

  beat_t qa[$];
  beat_t qb[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic beat_t mk(logic [31:0] d, logic l);
    return {d[7:4], l, d[3:0] ^ 4'h5, d};
  endfunction

  task automatic a_drive(logic v, logic [31:0] d, logic l);
    a_ivalid = v; a_idata = d; a_ilast = l; a_ikeep = d[3:0] ^ 4'h5; a_iuser = d[7:4];
  endtask

  task automatic b_drive(logic v, logic [31:0] d, logic l);
    b_ivalid = v; b_idata = d; b_ilast = l; b_ikeep = d[3:0] ^ 4'h5; b_iuser = d[7:4];
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Monitors: a handshake seen at negedge completes at the next rising edge.
  always @(negedge clk_i) begin
    if (rst_n_i && !a_clr && a_ovalid && a_oready) begin
      if (qa.size() == 0) begin
        total_cnt++;
        $display("FAIL a_unexpected_beat: got %0h expected none", a_odata);
      end else begin
        chk("a_beat", {a_ouser, a_olast, a_okeep, a_odata}, qa.pop_front());
      end
    end
  end

  always @(negedge clk_i) begin
    if (rst_n_i && !b_clr && b_ovalid && b_oready) begin
      if (qb.size() == 0) begin
        total_cnt++;
        $display("FAIL b_unexpected_beat: got %0h expected none", b_odata);
      end else begin
        chk("b_beat", {b_ouser, b_olast, b_okeep, b_odata}, qb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n_i = 1'b0;
    a_clr = 0; b_clr = 0; a_oready = 0; b_oready = 0;
    a_drive(0, 0, 0);
    b_drive(0, 0, 0);
    #12;
    chk("rst_a_iready", a_iready, 1);
    chk("rst_a_ovalid", a_ovalid, 0);
    chk("rst_a_empty", a_empty, 1);
    chk("rst_a_ae", a_ae, 1);
    chk("rst_a_flags", {a_full, a_hf, a_af, a_perr}, 4'b0000);
    chk("rst_a_level", a_level, 0);
    chk("rst_b_flags", {b_full, b_hf, b_af, b_perr, b_ae, b_empty, b_ovalid}, 7'b0000110);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    step();

    // Fill to full with the sink stalled.
    for (int i = 0; i < 16; i++) begin
      a_drive(1, i, i == 15);
      qa.push_back(mk(i, i == 15));
      step();
      chk("fill_level", a_level, i + 1);
      chk("fill_af", a_af, (i + 1) >= 12);
      chk("fill_hf", a_hf, (i + 1) > 8);
      chk("fill_full", a_full, i == 15);
      chk("fill_iready", a_iready, i != 15);
    end
    a_drive(1, 32'h99, 0);
    step();
    chk("overfill_level", a_level, 16);
    chk("overfill_iready", a_iready, 0);
    a_drive(0, 0, 0);

    // Drain in order.
    a_oready = 1;
    for (int k = 0; k < 16; k++) step();
    chk("drain_empty", a_empty, 1);
    chk("drain_ae", a_ae, 1);
    chk("drain_ovalid", a_ovalid, 0);
    chk("drain_level", a_level, 0);
    chk("drain_sb_left", qa.size(), 0);

    // Streaming across pointer wrap.
    for (int i = 0; i < 40; i++) begin
      a_drive(1, 32'h100 + i, 0);
      qa.push_back(mk(32'h100 + i, 0));
      step();
      chk("stream_level", a_level, 1);
      if (i == 0) begin
        chk("stream_first_valid", a_ovalid, 1);
        chk("stream_first_data", a_odata, 32'h100);
      end
    end
    a_drive(0, 0, 0);
    step();
    chk("stream_end_level", a_level, 0);
    chk("stream_sb_left", qa.size(), 0);

    // Flush with level 7 and simultaneous push/pop.
    a_oready = 0;
    for (int i = 0; i < 7; i++) begin
      a_drive(1, 32'h200 + i, 0);
      qa.push_back(mk(32'h200 + i, 0));
      step();
    end
    a_drive(0, 0, 0);
    chk("clr_pre_level", a_level, 7);
    a_clr = 1; a_oready = 1;
    a_drive(1, 32'h2FF, 0);
    step();
    a_clr = 0; a_oready = 0;
    a_drive(0, 0, 0);
    qa.delete();
    chk("clr_level", a_level, 0);
    chk("clr_empty", a_empty, 1);
    chk("clr_iready", a_iready, 1);
    chk("clr_ovalid", a_ovalid, 0);

    // Packet mode: 5-beat packet with a gap before TLAST.
    b_oready = 1;
    for (int i = 0; i < 4; i++) begin
      b_drive(1, 32'h300 + i, 0);
      qb.push_back(mk(32'h300 + i, 0));
      step();
      chk("pkt_hold_ovalid", b_ovalid, 0);
    end
    b_drive(0, 0, 0);
    repeat (2) begin
      step();
      chk("pkt_gap_ovalid", b_ovalid, 0);
    end
    b_drive(1, 32'h304, 1);
    qb.push_back(mk(32'h304, 1));
    chk("pkt_pre_last_ovalid", b_ovalid, 0);
    step();
    b_drive(0, 0, 0);
    chk("pkt_release_ovalid", b_ovalid, 1);
    repeat (5) step();
    chk("pkt_done_empty", b_empty, 1);
    chk("pkt_done_ovalid", b_ovalid, 0);
    chk("pkt_cnt_zero", b_dut.pkt_cnt_q, 0);
    chk("pkt_sb_left", qb.size(), 0);
    chk("pkt_no_err", b_perr, 0);

    // Packet mode: oversize packet forces drain.
    b_oready = 0;
    for (int i = 0; i < 16; i++) begin
      b_drive(1, 32'h400 + i, 0);
      qb.push_back(mk(32'h400 + i, 0));
      step();
      chk("big_hold_ovalid", b_ovalid, 0);
    end
    b_drive(0, 0, 0);
    step();
    chk("big_full", b_full, 1);
    chk("big_err", b_perr, 1);
    chk("big_drain_ovalid", b_ovalid, 1);
    b_oready = 1;
    step();
    b_drive(1, 32'h4AA, 1);
    qb.push_back(mk(32'h4AA, 1));
    chk("big_tail_iready", b_iready, 1);
    step();
    b_drive(0, 0, 0);
    for (int k = 0; k < 20 && !b_empty; k++) step();
    chk("big_empty", b_empty, 1);
    chk("big_drain_end", b_dut.drain_q, 0);
    chk("big_pkt_cnt", b_dut.pkt_cnt_q, 0);
    chk("big_err_sticky", b_perr, 1);
    chk("big_sb_left", qb.size(), 0);
    b_oready = 0;
    for (int i = 0; i < 2; i++) begin
      b_drive(1, 32'h4C0 + i, 0);
      qb.push_back(mk(32'h4C0 + i, 0));
      step();
    end
    b_drive(0, 0, 0);
    chk("bclr_pre_level", b_level, 2);
    b_clr = 1;
    step();
    b_clr = 0;
    qb.delete();
    chk("bclr_err", b_perr, 0);
    chk("bclr_level", b_level, 0);
    chk("bclr_empty", b_empty, 1);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 3; i++) begin
      a_drive(1, 32'h500 + i, 0);
      qa.push_back(mk(32'h500 + i, 0));
      step();
    end
    a_drive(0, 0, 0);
    chk("arst_pre_ovalid", a_ovalid, 1);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("arst_ovalid", a_ovalid, 0);
    chk("arst_level", a_level, 0);
    chk("arst_iready", a_iready, 1);
    qa.delete();
    qb.delete();
    @(posedge clk_i);
    #3;
    rst_n_i = 1'b1;
    step();
    a_drive(1, 32'h5AB, 1);
    qa.push_back(mk(32'h5AB, 1));
    step();
    a_drive(0, 0, 0);
    chk("post_rst_level", a_level, 1);
    chk("post_rst_data", a_odata, 32'h5AB);
    a_oready = 1;
    step();
    chk("post_rst_empty_level", a_level, 0);
    chk("post_rst_sb_left", qa.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
